// File: rtl/aes_round_controller.sv
`default_nettype none
//==============================================================================
// aes_round_controller : iterative AES round sequencer with internal AddRoundKey
// Revision 1.0
//==============================================================================
module aes_round_controller #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         rk_req,
  output logic [3:0]   rk_idx,
  input  logic         rk_valid,
  input  logic [127:0] rk_data,
  output logic [127:0] core_in,
  output logic         core_mix_en,
  input  logic [127:0] core_out,
  output logic         busy
);

  localparam logic [3:0] c_LAST_ROUND = 4'(NR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t       r_fsm;
  state_t       w_fsm_nxt;
  logic [127:0] r_state;
  logic [127:0] w_state_nxt;
  logic [3:0]   r_round;
  logic [3:0]   w_round_nxt;
  logic         w_last;

  assign w_last = (r_round == c_LAST_ROUND);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm   <= S_IDLE;
      r_state <= '0;
      r_round <= '0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    rk_req      = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = in_data;
          w_round_nxt = 4'd0;
          w_fsm_nxt   = S_ROUND;
        end
      end
      S_ROUND: begin
        rk_req = 1'b1;
        if (rk_valid) begin
          // Round 0 is the initial whitening key; the core result is unused there.
          w_state_nxt = ((r_round == 4'd0) ? r_state : core_out) ^ rk_data;
          if (w_last) begin
            w_fsm_nxt = S_DONE;
          end else begin
            w_round_nxt = r_round + 4'd1;
          end
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_fsm_nxt = S_IDLE;
        end
      end
      default: begin
        w_fsm_nxt = S_IDLE;
      end
    endcase
  end

  assign rk_idx      = r_round;
  assign out_data    = r_state;
  assign core_in     = r_state;
  assign core_mix_en = ~w_last;
  assign busy        = (r_fsm != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aes_round_controller.sv
`default_nettype none
// Bench for aes_round_controller: NR=10 and NR=14 instances driven by a reference
// AES round core and key schedule, checked against FIPS-197 ciphertexts.
module tb_aes_round_controller;

  localparam logic [127:0] c_K128  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] c_K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] c_PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] c_CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] c_CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] c_KB    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] c_PTB   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] c_CTB   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       in_valid, in_ready, out_valid, out_ready;
  logic [1:0]       rk_req, rk_valid, core_mix_en, busy;
  logic [1:0][3:0]  rk_idx;
  logic [1:0][127:0] in_data, out_data, rk_data, core_in, core_out;
  logic [127:0]     rks [2][16];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  aes_round_controller #(.NR(10)) u_dut10 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .rk_req(rk_req[0]), .rk_idx(rk_idx[0]), .rk_valid(rk_valid[0]), .rk_data(rk_data[0]),
    .core_in(core_in[0]), .core_mix_en(core_mix_en[0]), .core_out(core_out[0]),
    .busy(busy[0])
  );

  aes_round_controller #(.NR(14)) u_dut14 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .rk_req(rk_req[1]), .rk_idx(rk_idx[1]), .rk_valid(rk_valid[1]), .rk_data(rk_data[1]),
    .core_in(core_in[1]), .core_mix_en(core_mix_en[1]), .core_out(core_out[1]),
    .busy(busy[1])
  );

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, v;
    sq = x; v = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gmul(sq, sq);
      v  = gmul(v, sq);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] x, input logic mix);
    logic [7:0]   a [16];
    logic [7:0]   t [16];
    logic [7:0]   b0, b1, b2, b3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox(x[127-8*i -: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r+4*c] = a[r + 4*((c+r)%4)];
    if (mix) begin
      for (int c = 0; c < 4; c++) begin
        b0 = t[4*c]; b1 = t[4*c+1]; b2 = t[4*c+2]; b3 = t[4*c+3];
        t[4*c]   = xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3;
        t[4*c+1] = b0 ^ xt(b1) ^ xt(b2) ^ b2 ^ b3;
        t[4*c+2] = b0 ^ b1 ^ xt(b2) ^ xt(b3) ^ b3;
        t[4*c+3] = xt(b0) ^ b0 ^ b1 ^ b2 ^ xt(b3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o;
  endfunction

  function automatic logic [127:0] aes_ref(input int s, input logic [127:0] pt);
    int nr;
    logic [127:0] v;
    nr = (s != 0) ? 14 : 10;
    v = pt ^ rks[s][0];
    for (int r = 1; r <= nr; r++) v = aes_round(v, r != nr) ^ rks[s][r];
    return v;
  endfunction

  task automatic expand_key(input int s, input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] temp;
    logic [7:0]  rcon;
    int nr;
    nr = (s != 0) ? 14 : 10;
    rcon = 8'h01;
    for (int i = 0; i < 4*(nr+1); i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else begin
        temp = w[i-1];
        if (i % nk == 0) begin
          temp = subword({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
          rcon = xt(rcon);
        end else if (nk > 6 && i % nk == 4) begin
          temp = subword(temp);
        end
        w[i] = w[i-nk] ^ temp;
      end
    end
    for (int r = 0; r < 16; r++)
      rks[s][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  always_comb begin
    core_out[0] = aes_round(core_in[0], core_mix_en[0]);
    core_out[1] = aes_round(core_in[1], core_mix_en[1]);
    rk_data[0]  = rks[0][rk_idx[0]];
    rk_data[1]  = rks[1][rk_idx[1]];
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Push one block through DUT s; observation happens 1 time unit after each edge.
  task automatic run_block(input int s, input logic [127:0] pt, input int maxstall,
                           input bit spur, input int bp, input bit hold_next,
                           input logic [127:0] next_pt, output logic [127:0] ct,
                           output int lat, output int stalls);
    int nr = (s != 0) ? 14 : 10;
    int exp_idx = 0;
    int stall_left = 0;
    bit new_req = 1'b1;
    bit seq_ok = 1'b1;
    bit mix_ok = 1'b1;
    bit stable_ok = 1'b1;
    check("in_ready_before_accept", 128'(in_ready[s]), 128'd1);
    in_valid[s] = 1'b1;
    in_data[s]  = pt;
    @(posedge clk); #1;
    in_valid[s] = 1'b0;
    in_data[s]  = {$urandom, $urandom, $urandom, $urandom};
    lat = 0; stalls = 0;
    while (!out_valid[s] && lat < 400) begin
      if (!rk_req[s] || !busy[s] || in_ready[s]) seq_ok = 1'b0;
      if (rk_idx[s] != 4'(exp_idx)) seq_ok = 1'b0;
      if (exp_idx != 0 && core_mix_en[s] != (exp_idx != nr)) mix_ok = 1'b0;
      if (new_req) begin
        stall_left = (maxstall > 0) ? int'($urandom_range(0, maxstall)) : 0;
        new_req = 1'b0;
      end
      if (stall_left > 0) begin
        rk_valid[s] = 1'b0;
        stall_left--;
        stalls++;
      end else begin
        rk_valid[s] = 1'b1;
        exp_idx++;
        new_req = 1'b1;
      end
      if (spur) begin
        in_valid[s] = 1'($urandom_range(0, 1));
        in_data[s]  = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge clk); #1;
      lat++;
    end
    rk_valid[s] = 1'b0;
    in_valid[s] = 1'b0;
    check("latency", 128'(lat), 128'(nr + 1 + stalls));
    check("rk_idx_sequence_held", 128'(seq_ok), 128'd1);
    check("rk_request_count", 128'(exp_idx), 128'(nr + 1));
    check("core_mix_en_pattern", 128'(mix_ok), 128'd1);
    ct = out_data[s];
    for (int k = 0; k < bp; k++) begin
      out_ready[s] = 1'b0;
      if (hold_next) begin
        in_valid[s] = 1'b1;
        in_data[s]  = next_pt;
      end
      if (spur) rk_valid[s] = 1'($urandom_range(0, 1));
      if (out_data[s] !== ct || !out_valid[s] || in_ready[s]) stable_ok = 1'b0;
      @(posedge clk); #1;
    end
    check("backpressure_hold", 128'(stable_ok), 128'd1);
    out_ready[s] = 1'b1;
    if (hold_next) begin
      in_valid[s] = 1'b1;
      in_data[s]  = next_pt;
    end
    @(posedge clk); #1;
    out_ready[s] = 1'b0;
    rk_valid[s]  = 1'b0;
    check("in_ready_after_done", 128'(in_ready[s]), 128'd1);
    check("busy_after_done", 128'(busy[s]), 128'd0);
    check("out_valid_after_done", 128'(out_valid[s]), 128'd0);
    check("idle_holds_result", out_data[s], ct);
  endtask

  typedef struct {
    int           sel;
    logic [255:0] key;
    int           nk;
    logic [127:0] pt;
    logic [127:0] ct;
    int           maxstall;
    bit           spur;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [127:0] ct, pt2;
    int lat, stalls;
    bit quiet_ok;

    vecs[0] = '{0, {c_K128, 128'h0}, 4, c_PT,  c_CT128, 0, 1'b0};
    vecs[1] = '{1, c_K256,           8, c_PT,  c_CT256, 0, 1'b0};
    vecs[2] = '{0, {c_K128, 128'h0}, 4, c_PT,  c_CT128, 5, 1'b0};
    vecs[3] = '{0, {c_KB, 128'h0},   4, c_PTB, c_CTB,   5, 1'b1};
    vecs[4] = '{1, c_K256,           8, c_PT,  c_CT256, 5, 1'b1};
    vecs[5] = '{0, {c_KB, 128'h0},   4, c_PTB, c_CTB,   0, 1'b1};

    reset = 1'b1;
    in_valid = '0; out_ready = '0; rk_valid = '0; in_data = '0;
    expand_key(0, {c_K128, 128'h0}, 4);
    expand_key(1, c_K256, 8);
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check("reset_in_ready", 128'(in_ready[s]), 128'd1);
      check("reset_out_valid", 128'(out_valid[s]), 128'd0);
      check("reset_rk_req", 128'(rk_req[s]), 128'd0);
      check("reset_rk_idx", 128'(rk_idx[s]), 128'd0);
      check("reset_busy", 128'(busy[s]), 128'd0);
      check("reset_out_data", out_data[s], 128'd0);
      check("reset_core_in", core_in[s], 128'd0);
    end
    reset = 1'b0;

    // Key-valid pulses while idle must not start anything.
    rk_valid[0] = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rk_valid[0] = 1'b0;
    check("idle_rk_valid_busy", 128'(busy[0]), 128'd0);
    check("idle_rk_valid_state", out_data[0], 128'd0);

    for (int i = 0; i < 6; i++) begin
      expand_key(vecs[i].sel, vecs[i].key, vecs[i].nk);
      run_block(vecs[i].sel, vecs[i].pt, vecs[i].maxstall, vecs[i].spur, 0, 1'b0, '0,
                ct, lat, stalls);
      check($sformatf("vec%0d_ciphertext", i), ct, vecs[i].ct);
    end

    // Long backpressure with the next block already waiting at the input.
    expand_key(0, {c_K128, 128'h0}, 4);
    pt2 = 128'hfedcba98765432100123456789abcdef;
    run_block(0, c_PT, 0, 1'b1, 20, 1'b1, pt2, ct, lat, stalls);
    check("bp_first_ciphertext", ct, c_CT128);
    run_block(0, pt2, 2, 1'b0, 0, 1'b0, '0, ct, lat, stalls);
    check("bp_second_ciphertext", ct, aes_ref(0, pt2));

    // Reset while round 5 is being requested, with every handshake also active.
    in_valid[0] = 1'b1;
    in_data[0]  = c_PT;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    rk_valid[0] = 1'b1;
    for (int k = 0; k < 20 && rk_idx[0] != 4'd5; k++) begin @(posedge clk); #1; end
    check("reached_round5", 128'(rk_idx[0]), 128'd5);
    reset = 1'b1;
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b0;
    rk_valid[0] = 1'b0;
    check("rst_mid_rk_req", 128'(rk_req[0]), 128'd0);
    check("rst_mid_out_valid", 128'(out_valid[0]), 128'd0);
    check("rst_mid_in_ready", 128'(in_ready[0]), 128'd1);
    check("rst_mid_busy", 128'(busy[0]), 128'd0);
    check("rst_mid_out_data", out_data[0], 128'd0);
    check("rst_mid_rk_idx", 128'(rk_idx[0]), 128'd0);
    quiet_ok = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid[0] || busy[0]) quiet_ok = 1'b0;
    end
    check("rst_no_out_pulse", 128'(quiet_ok), 128'd1);
    run_block(0, c_PT, 3, 1'b1, 0, 1'b0, '0, ct, lat, stalls);
    check("post_reset_ciphertext", ct, c_CT128);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
